// File: rtl/fir_filter_serial_mac_pkg.sv
// Shared types for the serial-MAC FIR filter.
package fir_filter_serial_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

endpackage

// File: rtl/fir_filter_serial_mac_mac_unit.sv
// Signed multiply-accumulate with synchronous clear and enable.
module fir_filter_serial_mac_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc_next
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  assign prod     = a * b;
  // Exposed so the final sum can be saturated in the same edge that completes it.
  assign acc_next = acc + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/fir_filter_serial_mac.sv
// FIR filter with runtime-loadable taps and a single time-shared multiplier.
//   state   | meaning
//   IDLE    | ready for a sample and coefficient writes
//   MAC     | one product per cycle, tap k = 0..TAPS-1
//   OUT     | y/y_valid presented for one cycle, then back to IDLE
module fir_filter_serial_mac
  import fir_filter_serial_mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 11,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [DATA_W-1:0]   x,
  input  logic                       x_valid,
  output logic                       x_ready,
  output logic signed [OUT_W-1:0]    y,
  output logic                       y_valid,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  output logic                       coef_err
);

  localparam int ADDR_W = $clog2(TAPS);
  localparam int ACC_W  = DATA_W + COEF_W + ADDR_W;
  localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [SAT_W-1:0] SAT_MAX = {{(SAT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN = {{(SAT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  fir_state_e               state;
  logic [ADDR_W-1:0]        k;
  logic signed [DATA_W-1:0] d [TAPS];
  logic signed [COEF_W-1:0] h [TAPS];
  logic                     xfer;
  logic                     addr_ok;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  acc_shift;
  logic signed [SAT_W-1:0]  sh_ext;
  logic signed [OUT_W-1:0]  y_next;

  assign x_ready = rst & (state == ST_IDLE);
  assign xfer    = x_valid & x_ready;
  // One extra bit so TAPS equal to a power of two still compares correctly.
  assign addr_ok = {1'b0, coef_addr} < (ADDR_W + 1)'(TAPS);

  fir_filter_serial_mac_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clr      (xfer),
    .en       (state == ST_MAC),
    .a        (d[k]),
    .b        (h[k]),
    .acc_next (acc_next)
  );

  assign acc_shift = acc_next >>> SHIFT;
  assign sh_ext    = SAT_W'(acc_shift);

  always_comb begin
    y_next = sh_ext[OUT_W-1:0];
    if (sh_ext > SAT_MAX) begin
      y_next = SAT_MAX[OUT_W-1:0];
    end else if (sh_ext < SAT_MIN) begin
      y_next = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      k        <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      coef_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        h[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;

      if (coef_we) begin
        if (state == ST_IDLE && addr_ok) begin
          h[coef_addr] <= coef_data;
        end else begin
          coef_err <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            d[0] <= x;
            for (int i = 1; i < TAPS; i++) begin
              d[i] <= d[i-1];
            end
            k     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          k <= k + 1'b1;
          if (k == K_LAST) begin
            y       <= y_next;
            y_valid <= 1'b1;
            state   <= ST_OUT;
          end
        end
        ST_OUT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
